// File: rtl/timer_pkg.sv
// Timer device shared definitions: register offsets, CTRL bit fields,
// MODE encodings and FSM state encoding.
package timer_pkg;

   localparam logic [1:0] ADDR_CTRL     = 2'd0;
   localparam logic [1:0] ADDR_PRESET   = 2'd1;
   localparam logic [1:0] ADDR_COUNT    = 2'd2;
   localparam logic [1:0] ADDR_PRESCALE = 2'd3;

   localparam int CTRL_EN      = 0;
   localparam int CTRL_MODE_LO = 1;
   localparam int CTRL_MODE_HI = 2;
   localparam int CTRL_IM      = 3;

   localparam logic [1:0] MODE_ONESHOT  = 2'b00;
   localparam logic [1:0] MODE_PERIODIC = 2'b01;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_CNT  = 2'd2,
      S_INT  = 2'd3
   } state_t;

   // Only 01 reloads; 00 and 1x behave as one-shot.
   function automatic logic is_periodic(input logic [1:0] mode);
      return mode == MODE_PERIODIC;
   endfunction

endpackage

// File: rtl/timer_if.sv
// Bridge-side register bus of the timer: select, word offset, write strike,
// write/read data and interrupt request. master = bridge, slave = timer.
interface timer_if;

   logic        dev_sel;
   logic [1:0]  addr;
   logic        we;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        irq;

   modport master (
      output dev_sel, addr, we, wdata,
      input  rdata, irq
   );

   modport slave (
      input  dev_sel, addr, we, wdata,
      output rdata, irq
   );

endinterface

// File: rtl/timer_prescaler.sv
// Tick generator: one o_tick every i_div+1 clocks; i_clr restarts the phase.
// Ports: i_clk, i_rst_n (async low), i_clr, i_div[7:0], o_tick.
module timer_prescaler (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_clr,
   input  logic [7:0] i_div,
   output logic       o_tick
);

   logic [7:0] r_cnt;
   logic       w_wrap;

   assign w_wrap = (r_cnt == i_div);
   assign o_tick = w_wrap;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt <= 8'd0;
      end else if (i_clr || w_wrap) begin
         r_cnt <= 8'd0;
      end else begin
         r_cnt <= r_cnt + 8'd1;
      end
   end

endmodule

// File: rtl/timer_dev.sv
// Down-counting timer with one-shot/periodic modes and masked interrupt.
// Ports: clk, reset (async low), bus (timer_if.slave: dev_sel, addr, we,
// wdata, rdata, irq). Optional PRESCALE register under TIMER_PRESCALE_EN.
module timer_dev
   import timer_pkg::*;
(
   input  logic   clk,
   input  logic   reset,
   timer_if.slave bus
);

   logic [3:0]  r_ctrl;
   logic [31:0] r_preset;
   logic [31:0] r_count;
   state_t      r_state;
   state_t      w_state_nxt;

   logic        w_wr;
   logic        w_ctrl_wr;
   logic        w_preset_wr;
   logic        w_en_nxt;
   logic        w_periodic;
   logic        w_tick;
   logic [31:0] w_prescale_rd;

   assign w_wr        = bus.dev_sel && bus.we;
   assign w_ctrl_wr   = w_wr && (bus.addr == ADDR_CTRL);
   assign w_preset_wr = w_wr && (bus.addr == ADDR_PRESET);
   assign w_periodic  = is_periodic(r_ctrl[CTRL_MODE_HI:CTRL_MODE_LO]);

   // A CTRL write landing this cycle overrides the stored EN, so a
   // disable beats a simultaneous terminal count.
   assign w_en_nxt = w_ctrl_wr ? bus.wdata[CTRL_EN] : r_ctrl[CTRL_EN];

`ifdef TIMER_PRESCALE_EN
   logic [7:0] r_prescale;
   logic       w_presc_wr;

   assign w_presc_wr    = w_wr && (bus.addr == ADDR_PRESCALE);
   assign w_prescale_rd = {24'd0, r_prescale};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_prescale <= 8'd0;
      end else if (w_presc_wr) begin
         r_prescale <= bus.wdata[7:0];
      end
   end

   timer_prescaler u_presc (
      .i_clk   (clk),
      .i_rst_n (reset),
      .i_clr   (r_state == S_LOAD),
      .i_div   (r_prescale),
      .o_tick  (w_tick)
   );
`else
   assign w_tick        = 1'b1;
   assign w_prescale_rd = 32'd0;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      if (w_preset_wr) begin
         w_state_nxt = S_IDLE;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (r_ctrl[CTRL_EN]) w_state_nxt = S_LOAD;
            end
            S_LOAD: begin
               if (r_preset == 32'd0) w_state_nxt = S_INT;
               else                   w_state_nxt = S_CNT;
            end
            S_CNT: begin
               if (!w_en_nxt)
                  w_state_nxt = S_IDLE;
               else if (w_tick && (r_count == 32'd1))
                  w_state_nxt = S_INT;
            end
            S_INT: begin
               if (w_ctrl_wr)       w_state_nxt = S_IDLE;
               else if (w_periodic) w_state_nxt = S_LOAD;
            end
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   // One-shot completion drops EN so the timer parks after the interrupt.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_ctrl <= 4'd0;
      end else if (w_ctrl_wr) begin
         r_ctrl <= bus.wdata[3:0];
      end else if ((r_state == S_INT) && !w_periodic) begin
         r_ctrl[CTRL_EN] <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_preset <= 32'd0;
      end else if (w_preset_wr) begin
         r_preset <= bus.wdata;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_count <= 32'd0;
      end else if (r_state == S_LOAD) begin
         r_count <= r_preset;
      end else if ((r_state == S_CNT) && w_tick && (r_count != 32'd0)) begin
         r_count <= r_count - 32'd1;
      end
   end

   always_comb begin
      bus.rdata = 32'd0;
      unique case (bus.addr)
         ADDR_CTRL:     bus.rdata = {28'd0, r_ctrl};
         ADDR_PRESET:   bus.rdata = r_preset;
         ADDR_COUNT:    bus.rdata = r_count;
         ADDR_PRESCALE: bus.rdata = w_prescale_rd;
         default:       bus.rdata = 32'd0;
      endcase
   end

   assign bus.irq = r_ctrl[CTRL_IM] && (r_state == S_INT);

endmodule

// File: doc/timer_dev.md
TIMER_DEV -- requirements
Module: timer_dev

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state on rising edge.
REQ-002 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port dev_sel, input, 1, bridge select; the access targets this timer.
REQ-004 SHALL have port addr, input, 2, word offset (PrAddr[3:2]): 0 CTRL, 1 PRESET, 2 COUNT, 3 PRESCALE.
REQ-005 SHALL have port we, input, 1, write strike (CPU_Wr qualified by dev_sel).
REQ-006 SHALL have port wdata, input, 32, write data (PrWd).
REQ-007 SHALL have port rdata, output, 32, read data returned to the bridge as PrRd.
REQ-008 SHALL have port irq, output, 1, interrupt request to the bridge (drives IntReq).

Function
REQ-009 SHALL drive rdata combinationally from addr: CTRL zero-extended from 4 bits, PRESET, COUNT, and PRESCALE (or 0 when PRESCALE is absent).
REQ-010 SHALL decode CTRL as bit0 EN, bits[2:1] MODE (00 one-shot, 01 periodic, 1x treated as one-shot), bit3 IM (interrupt mask); bits[31:4] SHALL be ignored on write.
REQ-011 SHALL register writes on the clock edge when dev_sel&&we; a write to COUNT SHALL be ignored.
REQ-012 SHALL run FSM states IDLE, LOAD, CNT, INT.
REQ-013 In IDLE, SHALL hold COUNT and go to LOAD on the cycle after EN=1.
REQ-014 In LOAD, SHALL set COUNT<=PRESET and go to CNT, or go to INT when PRESET==0.
REQ-015 In CNT, SHALL decrement COUNT by 1 per tick (every clk when prescale is absent) and go to INT on the tick that makes COUNT 0; EN=0 SHALL force IDLE.
REQ-016 In INT with one-shot MODE, SHALL clear EN, hold COUNT=0, and stay in INT until a CTRL or PRESET write, then go to IDLE.
REQ-017 In INT with periodic MODE, SHALL stay one cycle and then go to LOAD, so COUNT reloads without software action.
REQ-018 SHALL drive irq=IM&&(state==INT) as a registered-state decode; one-shot gives a level irq, periodic gives a one-cycle pulse.
REQ-019 A PRESET write in any state SHALL move the FSM to IDLE and deassert irq the next cycle; it restarts through LOAD if EN=1.
REQ-020 When a CTRL write with EN=0 coincides with COUNT reaching 0, the write SHALL win: state IDLE, irq never asserted.
REQ-021 COUNT SHALL never wrap below 0; PRESET=0xFFFF_FFFF SHALL count the full 32-bit range.

Reset
REQ-022 When reset==0, SHALL asynchronously set CTRL=0, PRESET=0, COUNT=0, PRESCALE=0, prescale counter=0, state IDLE, irq=0.
REQ-023 Reset asserted mid-count SHALL abort the count immediately; after release, the FSM SHALL remain in IDLE until EN is written.

Configuration
REQ-024 When macro TIMER_PRESCALE_EN is defined, SHALL implement 8-bit PRESCALE at offset 3 that generates one tick every PRESCALE+1 clocks; the prescale counter SHALL clear on LOAD.
REQ-025 When TIMER_PRESCALE_EN is undefined, the tick SHALL be constant 1, offset 3 SHALL read 0, and writes to offset 3 SHALL be ignored.

Structure
REQ-026 Package timer_pkg SHALL hold the register offsets, CTRL bit positions, MODE encodings and FSM state encoding.
REQ-027 Sub-module timer_prescaler (tick generator) SHALL be instantiated only under TIMER_PRESCALE_EN.

Verification
REQ-028 Scenario: reset low mid-count -> all registers read 0 and irq=0 in the same cycle.
REQ-029 Scenario: PRESET=5, CTRL=0x9 (EN, one-shot, IM) -> COUNT reads 5,4,3,2,1,0; irq rises 7 clocks after the CTRL write and stays high; a CTRL read returns 0x8; a PRESET write clears irq.
REQ-030 Scenario: PRESET=3, CTRL=0xB (periodic) -> irq is a one-cycle pulse every 5 clocks, repeated at least 3 times; COUNT reloads to 3 each time.
REQ-031 Scenario: CTRL write 0x8 on the cycle COUNT goes 1->0 -> state IDLE, irq stays 0, COUNT reads 0.
REQ-032 Scenario: PRESET=0 with EN=1 -> INT one cycle after LOAD; with IM=0, irq stays 0 while COUNT=0.
REQ-033 Scenario: with TIMER_PRESCALE_EN, PRESCALE=2, PRESET=2 -> COUNT decrements every 3 clocks; irq asserts after 6 counting clocks.
